mux_rr_arb_8: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 8:1 bit-select mux among 8 requesters.
//  - Picks one active requester and drives the mux select from registered state.
//  - Holds the grant for a bounded burst, then rotates to the next requester.
//  - Registers the selected data bit.
//  - Sits between eight 1-bit serial sources and a single shared output lane.

---
 rtl/mux_arb_pkg.sv | 37 +++
 rtl/mux_rr_arb_8_pick.sv | 21 ++
 rtl/mux_rr_arb_8.sv | 134 +++++++++++++
 tb/tb_mux_rr_arb_8.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and rotate-priority helper
// for the 8-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping 7->0.
  // Walks offsets high to low so the lowest offset wins.
  function automatic pick_t rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [SEL_W-1:0] ptr
  );
    pick_t            r;
    logic [SEL_W-1:0] j;
    r = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      j = ptr + SEL_W'(k);
      if (req[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arb_8_pick.sv
// Combinational rotate-priority encoder: req, ptr -> idx, found.
// Thin wrapper around rr_pick so the top sees a clean boundary.
module rr_pick_8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);

  pick_t p;

  // Single-shot search, no state.
  always_comb begin
    p       = rr_pick(req_i, ptr_i);
    idx_o   = p.idx;
    found_o = p.found;
  end

endmodule

// File: rtl/mux_rr_arb_8.sv
// Round-robin 8:1 bit-select mux arbiter with bounded bursts.
// Optional grant lock enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arb_8
  import mux_arb_pkg::*;
#(
  parameter  int MAX_HOLD = 4,
  localparam int HOLD_W   = $clog2(MAX_HOLD+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_valid,
  output logic             data_out,
  output logic             data_vld
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             gv_q, gv_d;
  logic             dout_q, dvld_q;

  logic [SEL_W-1:0] pk_ptr;
  logic [SEL_W-1:0] pk_idx;
  logic             pk_found;
  logic             own_req;
  logic             lock_on;
  logic             at_max;

`ifdef MUX_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  assign own_req = req[sel_q];
  assign at_max  = (hold_q == HOLD_W'(MAX_HOLD));

  // Idle searches from ptr; a releasing owner searches from owner+1.
  assign pk_ptr = (state_q == GRANT) ? sel_q + 1'b1 : ptr_q;

  rr_pick_8 u_pick (
    .req_i   (req),
    .ptr_i   (pk_ptr),
    .idx_o   (pk_idx),
    .found_o (pk_found)
  );

  // Next grant: arbitrate from idle or on release, else extend the burst.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    gv_d    = gv_q;
    unique case (state_q)
      IDLE: begin
        if (pk_found) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(1) << pk_idx;
          sel_d   = pk_idx;
          gv_d    = 1'b1;
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!own_req || (at_max && !lock_on)) begin
          ptr_d = pk_ptr;
          if (pk_found) begin
            gnt_d  = N_REQ'(1) << pk_idx;
            sel_d  = pk_idx;
            gv_d   = 1'b1;
            hold_d = HOLD_W'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            gv_d    = 1'b0;
            hold_d  = '0;
          end
        end else if (!lock_on && !at_max) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state; reset aborts any grant immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      gv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      gv_q    <= gv_d;
    end
  end

  // Output lane: sample the selected bit one cycle behind sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 1'b0;
      dvld_q <= 1'b0;
    end else begin
      dvld_q <= gv_q;
      if (gv_q) dout_q <= data_in[sel_q];
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = gv_q;
  assign data_out  = dout_q;
  assign data_vld  = dvld_q;

endmodule

// File: tb/tb_mux_rr_arb_8.sv
// Self-checking bench for mux_rr_arb_8 (directed + random).
// Honours MUX_ARB_LOCK_EN when defined.
module tb_mux_rr_arb_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       data_out;
  logic       data_vld;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_rr_arb_8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .data_out  (data_out),
    .data_vld  (data_vld)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference: owner index (-1 = nobody), burst length, search start.
  int m_own = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_dout = 1'b0;
  bit m_dvld = 1'b0;

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit lk;
`ifdef MUX_ARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    if (rst) begin
      m_own = -1; m_cnt = 0; m_ptr = 0;
      m_dout = 1'b0; m_dvld = 1'b0;
    end else begin
      if (m_own >= 0) m_dout = data_in[m_own];
      m_dvld = (m_own >= 0);
      if (m_own < 0) begin
        m_own = pick(req, m_ptr);
        m_cnt = (m_own >= 0) ? 1 : 0;
      end else if (req[m_own] && (lk || m_cnt < MH)) begin
        if (!lk) m_cnt++;
      end else begin
        m_ptr = (m_own + 1) % 8;
        m_own = pick(req, m_ptr);
        m_cnt = (m_own >= 0) ? 1 : 0;
      end
    end
  end

  task automatic check_model();
    logic [7:0] eg;
    eg = (m_own >= 0) ? 8'(1 << m_own) : 8'h00;
    chk("gnt",   32'(gnt), 32'(eg));
    chk("sel",   32'(sel), (m_own >= 0) ? m_own : 0);
    chk("gv",    32'(gnt_valid), 32'(m_own >= 0));
    chk("dvld",  32'(data_vld), 32'(m_dvld));
    chk("dout",  32'(data_out), 32'(m_dout));
  endtask

  // Called at a negedge: drive, clock once, compare at next negedge.
  task automatic cyc(
    input logic       r,
    input logic [7:0] rq,
    input logic [7:0] d
  );
    rst = r; req = rq; data_in = d;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] rq;
    int         s;
    rst = 1'b1; lock = 1'b0; req = 8'hFF; data_in = 8'h00;
    @(negedge clk);

    // 1) reset held with all requests
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'hFF, 8'h00);
      chk("t1_gnt", 32'(gnt), 0);
      chk("t1_gv",  32'(gnt_valid), 0);
      chk("t1_dv",  32'(data_vld), 0);
    end

    // 2) full load: bursts of MH, no gaps, wrap 7->0
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 8'hFF, 8'h00);
      chk("t2_sel", 32'(sel), (i / MH) % 8);
      chk("t2_gv",  32'(gnt_valid), 1);
    end

    // 3) owner 2 drops after 2 cycles, 5 keeps priority
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h24, 8'h00);
    chk("t3_a", 32'(sel), 2);
    cyc(1'b0, 8'h24, 8'h00);
    chk("t3_b", 32'(sel), 2);
    cyc(1'b0, 8'h20, 8'h00);
    chk("t3_c", 32'(sel), 5);
    cyc(1'b0, 8'h24, 8'h00);
    chk("t3_d", 32'(sel), 5);

    // 4) lone requester is re-granted without gaps
    cyc(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h08, 8'h00);
      chk("t4_gnt", 32'(gnt), 32'h08);
      chk("t4_gv",  32'(gnt_valid), 1);
    end

    // 5) data lane follows sel one cycle later
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'hFF, 8'hA5);
    for (int i = 0; i < 20; i++) begin
      s = m_own;
      d = (i % 2 == 0) ? 8'h5A : 8'hA5;
      cyc(1'b0, 8'hFF, d);
      chk("t5_dout", 32'(data_out), 32'(d[s]));
      chk("t5_dvld", 32'(data_vld), 1);
    end

    // 6) reset mid-grant clears grant and pointer
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h40, 8'h00);
    cyc(1'b0, 8'h40, 8'h00);
    chk("t6_sel", 32'(sel), 6);
    cyc(1'b1, 8'h40, 8'h00);
    chk("t6_gnt", 32'(gnt), 0);
    cyc(1'b0, 8'h41, 8'h00);
    chk("t6_ptr", 32'(sel), 0);

`ifdef MUX_ARB_LOCK_EN
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h40, 8'h00);
    lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'hC1, 8'h00);
      chk("t6_lock", 32'(sel), 6);
    end
    cyc(1'b0, 8'h81, 8'h00);
    chk("t6_drop", 32'(sel), 7);
    lock = 1'b0;
`endif

    // random traffic against the reference
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0: rq = 8'($urandom);
        1: rq = 8'($urandom) & 8'($urandom);
        2: rq = 8'(1 << $urandom_range(7));
        default: rq = ($urandom_range(3) == 0) ? 8'h00 : 8'hFF;
      endcase
`ifdef MUX_ARB_LOCK_EN
      lock = ($urandom_range(3) == 0);
`endif
      cyc($urandom_range(59) == 0, rq, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
